jam_cost_arbiter: RTL and testbench

Round-robin arbiter that shares the single cost-table port (W, J → Cost) between two permutation-search engines. Each engine requests exclusive ownership of the port for one burst of BURST_LEN lookups, one full assignment of 8 workers. Accepted lookups are forwarded to the table in order, and each returned Cost is routed back to its owner tagged with a burst-end marker. The arbiter sits between the engines and the external cost table.

---
 rtl/jam_pkg.sv | 13 +
 rtl/jam_rr_pick.sv | 17 +
 rtl/jam_cost_arbiter.sv | 167 ++++++++++++++++
 tb/tb_jam_cost_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// Shared types and widths for the cost-table arbiter.
package jam_pkg;
    localparam int ADDR_W        = 3;
    localparam int COST_W        = 7;
    localparam int DEF_BURST_LEN = 8;
    localparam int STAT_W        = 16;
    localparam int CNT_W         = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;
endpackage

// File: rtl/jam_rr_pick.sv
// Combinational two-way round-robin picker: on a tie the engine that did not
// own the port last time wins.
module jam_rr_pick (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       valid,
    output logic       pick
);
    always_comb begin
        valid = |req;
        if (&req) begin
            pick = ~last_owner;
        end else begin
            pick = req[1];
        end
    end
endmodule

// File: rtl/jam_cost_arbiter.sv
// Burst-ownership arbiter sharing one cost-table port between two engines.
// Optional per-engine completed-burst counters under JAM_ARB_STATS_EN.
module jam_cost_arbiter
    import jam_pkg::*;
#(
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] req0_W,
    input  logic [ADDR_W-1:0] req0_J,
    input  logic [ADDR_W-1:0] req1_W,
    input  logic [ADDR_W-1:0] req1_J,
    output logic [1:0]        gnt,
    output logic [ADDR_W-1:0] W,
    output logic [ADDR_W-1:0] J,
    input  logic [COST_W-1:0] Cost,
    output logic [1:0]        rsp_valid,
    output logic [COST_W-1:0] rsp_cost,
    output logic              rsp_last
`ifdef JAM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] burst_cnt0,
    output logic [STAT_W-1:0] burst_cnt1
`endif
);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;
    logic              last_owner_reg, last_owner_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [ADDR_W-1:0] w_reg, j_reg;
    logic              s1_valid_reg, s1_owner_reg, s1_last_reg;
    logic [1:0]        rsp_valid_reg;
    logic [COST_W-1:0] rsp_cost_reg;
    logic              rsp_last_reg;

    logic              pick_valid, pick;
    logic              owner_req, accept, burst_done;
    logic [ADDR_W-1:0] req_w [2];
    logic [ADDR_W-1:0] req_j [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_addr
            assign req_w[gi] = (gi == 0) ? req0_W : req1_W;
            assign req_j[gi] = (gi == 0) ? req0_J : req1_J;
        end
    endgenerate

    jam_rr_pick u_pick (
        .req        (req),
        .last_owner (last_owner_reg),
        .valid      (pick_valid),
        .pick       (pick)
    );

    assign owner_req  = req[owner_reg];
    assign accept     = |gnt;
    assign burst_done = accept && (cnt_reg == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b1;
            cnt_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            cnt_reg        <= cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        cnt_next        = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next = BURST;
                    owner_next = pick;
                    cnt_next   = '0;
                end
            end
            BURST: begin
                if (!owner_req) begin
                    // Abort: ownership is released and counts as this engine's turn.
                    state_next      = IDLE;
                    last_owner_next = owner_reg;
                end else begin
                    cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
                    if (burst_done) begin
                        state_next      = IDLE;
                        last_owner_next = owner_reg;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt = '0;
        if (state_reg == BURST) begin
            gnt[owner_reg] = req[owner_reg];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            w_reg         <= '0;
            j_reg         <= '0;
            s1_valid_reg  <= 1'b0;
            s1_owner_reg  <= 1'b0;
            s1_last_reg   <= 1'b0;
            rsp_valid_reg <= '0;
            rsp_cost_reg  <= '0;
            rsp_last_reg  <= 1'b0;
        end else begin
            if (accept) begin
                w_reg <= req_w[owner_reg];
                j_reg <= req_j[owner_reg];
            end
            s1_valid_reg  <= accept;
            s1_owner_reg  <= owner_reg;
            s1_last_reg   <= burst_done;
            rsp_valid_reg <= s1_valid_reg ? (2'b01 << s1_owner_reg) : 2'b00;
            rsp_last_reg  <= s1_valid_reg & s1_last_reg;
            // Cost is only meaningful one cycle after an accept.
            if (s1_valid_reg) begin
                rsp_cost_reg <= Cost;
            end
        end
    end

    assign W         = w_reg;
    assign J         = j_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_cost  = rsp_cost_reg;
    assign rsp_last  = rsp_last_reg;

`ifdef JAM_ARB_STATS_EN
    logic [STAT_W-1:0] burst_cnt_reg [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stats
            always_ff @(posedge CLK) begin
                if (RST) begin
                    burst_cnt_reg[gi] <= '0;
                end else if (burst_done && (owner_reg == 1'(gi)) &&
                             (burst_cnt_reg[gi] != '1)) begin
                    burst_cnt_reg[gi] <= burst_cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign burst_cnt0 = burst_cnt_reg[0];
    assign burst_cnt1 = burst_cnt_reg[1];
`endif
endmodule

// File: tb/tb_jam_cost_arbiter.sv
// Self-checking bench: two arbiters (burst length 8 and 2) share one stimulus
// stream and are compared against a transaction-level reference model.
module tb_jam_cost_arbiter;
    import jam_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] req;
    logic [2:0] r0w, r0j, r1w, r1j;

    logic [1:0] gnt_a, gnt_b, rv_a, rv_b;
    logic [2:0] w_a, j_a, w_b, j_b;
    logic [6:0] cost_a, cost_b, rc_a, rc_b;
    logic       rl_a, rl_b;
`ifdef JAM_ARB_STATS_EN
    logic [15:0] bc0_a, bc1_a, bc0_b, bc1_b;
`endif

    logic [6:0] tbl [64];

    always #5 CLK = ~CLK;

    assign cost_a = tbl[{w_a, j_a}];
    assign cost_b = tbl[{w_b, j_b}];

    jam_cost_arbiter #(.BURST_LEN(8)) dut_a (
        .CLK(CLK), .RST(RST), .req(req),
        .req0_W(r0w), .req0_J(r0j), .req1_W(r1w), .req1_J(r1j),
        .gnt(gnt_a), .W(w_a), .J(j_a), .Cost(cost_a),
        .rsp_valid(rv_a), .rsp_cost(rc_a), .rsp_last(rl_a)
`ifdef JAM_ARB_STATS_EN
        , .burst_cnt0(bc0_a), .burst_cnt1(bc1_a)
`endif
    );

    jam_cost_arbiter #(.BURST_LEN(2)) dut_b (
        .CLK(CLK), .RST(RST), .req(req),
        .req0_W(r0w), .req0_J(r0j), .req1_W(r1w), .req1_J(r1j),
        .gnt(gnt_b), .W(w_b), .J(j_b), .Cost(cost_b),
        .rsp_valid(rv_b), .rsp_cost(rc_b), .rsp_last(rl_b)
`ifdef JAM_ARB_STATS_EN
        , .burst_cnt0(bc0_b), .burst_cnt1(bc1_b)
`endif
    );

    // Reference model: ownership per instance plus a list of promised responses.
    typedef struct {
        int         due;
        int         inst;
        int         eng;
        logic [6:0] cost;
        logic       last;
    } rsp_t;

    rsp_t       pend[$];
    int         blen [2];
    bit         m_busy [2];
    int         m_owner [2];
    int         m_cnt [2];
    int         m_lo [2];
    logic [2:0] m_w [2];
    logic [2:0] m_j [2];
    logic [6:0] m_rc [2];
    int         m_bursts [2][2];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k]  = 1'b0;
            m_owner[k] = 0;
            m_cnt[k]   = 0;
            m_lo[k]    = 1;
            m_w[k]     = '0;
            m_j[k]     = '0;
            m_rc[k]    = '0;
            m_bursts[k][0] = 0;
            m_bursts[k][1] = 0;
        end
        pend.delete();
    endtask

    task automatic check_inst(input int k);
        logic [1:0] g, rv, eg, erv;
        logic [2:0] w, j;
        logic [6:0] rc, erc;
        logic       rl, erl;
        g  = (k == 0) ? gnt_a : gnt_b;
        w  = (k == 0) ? w_a   : w_b;
        j  = (k == 0) ? j_a   : j_b;
        rv = (k == 0) ? rv_a  : rv_b;
        rc = (k == 0) ? rc_a  : rc_b;
        rl = (k == 0) ? rl_a  : rl_b;
        eg  = (m_busy[k] && req[m_owner[k]]) ? 2'(1 << m_owner[k]) : 2'b00;
        erv = 2'b00;
        erl = 1'b0;
        erc = m_rc[k];
        foreach (pend[i]) begin
            if (pend[i].inst == k && pend[i].due == cyc) begin
                erv = 2'(1 << pend[i].eng);
                erc = pend[i].cost;
                erl = pend[i].last;
            end
        end
        m_rc[k] = erc;
        check($sformatf("gnt[%0d]", k), 16'(g), 16'(eg));
        check($sformatf("W[%0d]", k), 16'(w), 16'(m_w[k]));
        check($sformatf("J[%0d]", k), 16'(j), 16'(m_j[k]));
        check($sformatf("rsp_valid[%0d]", k), 16'(rv), 16'(erv));
        check($sformatf("rsp_cost[%0d]", k), 16'(rc), 16'(erc));
        check($sformatf("rsp_last[%0d]", k), 16'(rl), 16'(erl));
`ifdef JAM_ARB_STATS_EN
        check($sformatf("burst_cnt0[%0d]", k), (k == 0) ? bc0_a : bc0_b, 16'(m_bursts[k][0]));
        check($sformatf("burst_cnt1[%0d]", k), (k == 0) ? bc1_a : bc1_b, 16'(m_bursts[k][1]));
`endif
    endtask

    task automatic model_update();
        rsp_t r;
        if (RST) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (!m_busy[k]) begin
                if (req != 2'b00) begin
                    m_owner[k] = (req == 2'b11) ? 1 - m_lo[k] : (req[0] ? 0 : 1);
                    m_busy[k]  = 1'b1;
                    m_cnt[k]   = 0;
                end
            end else if (req[m_owner[k]]) begin
                m_w[k] = (m_owner[k] == 1) ? r1w : r0w;
                m_j[k] = (m_owner[k] == 1) ? r1j : r0j;
                m_cnt[k]++;
                r.due  = cyc + 2;
                r.inst = k;
                r.eng  = m_owner[k];
                r.cost = tbl[{m_w[k], m_j[k]}];
                r.last = (m_cnt[k] == blen[k]);
                pend.push_back(r);
                if (m_cnt[k] == blen[k]) begin
                    if (m_bursts[k][m_owner[k]] < 65535) m_bursts[k][m_owner[k]]++;
                    m_lo[k]   = m_owner[k];
                    m_busy[k] = 1'b0;
                end
            end else begin
                m_lo[k]   = m_owner[k];
                m_busy[k] = 1'b0;
            end
        end
    endtask

    task automatic step(input bit do_check);
        @(negedge CLK);
        if (do_check) begin
            check_inst(0);
            check_inst(1);
        end
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].due <= cyc) pend.delete(i);
        end
        model_update();
        @(posedge CLK);
        #1;
        cyc++;
        $display("cyc=%0d RST=%b req=%b gnt_a=%b rv_a=%b last_a=%b gnt_b=%b rv_b=%b last_b=%b",
                 cyc, RST, req, gnt_a, rv_a, rl_a, gnt_b, rv_b, rl_b);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        req = 2'b00;
        step(1);
        RST = 1'b0;
    endtask

    initial begin
        blen[0] = 8;
        blen[1] = 2;
        for (int i = 0; i < 64; i++) tbl[i] = 7'($urandom_range(0, 127));
        RST = 1'b1;
        req = 2'b00;
        r0w = '0; r0j = '0; r1w = '0; r1j = '0;
        model_reset();
        step(0);
        do_reset();

        // Single requester, addresses stepping.
        req = 2'b01;
        for (int i = 0; i < 14; i++) begin
            r0w = 3'(i);
            r0j = 3'(7 - i);
            step(1);
        end
        req = 2'b00;
        for (int i = 0; i < 4; i++) step(1);

        // Both requesting from reset: alternating bursts.
        do_reset();
        req = 2'b11;
        for (int i = 0; i < 30; i++) begin
            r0w = 3'($urandom); r0j = 3'($urandom);
            r1w = 3'($urandom); r1j = 3'($urandom);
            step(1);
        end
        req = 2'b00;
        for (int i = 0; i < 4; i++) step(1);

        // Engine 0 aborts after 3 accepts while engine 1 waits.
        do_reset();
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            r0w = 3'(i + 2); r0j = 3'(i);
            step(1);
        end
        req = 2'b10;
        for (int i = 0; i < 8; i++) begin
            r1w = 3'($urandom); r1j = 3'($urandom);
            step(1);
        end
        req = 2'b00;
        for (int i = 0; i < 4; i++) step(1);

        // Reset asserted during the fifth accept of a burst.
        do_reset();
        req = 2'b01;
        for (int i = 0; i < 5; i++) begin
            r0w = 3'($urandom); r0j = 3'($urandom);
            step(1);
        end
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        req = 2'b00;
        for (int i = 0; i < 4; i++) step(1);

        // Randomised contention, aborts and occasional resets.
        for (int i = 0; i < 400; i++) begin
            RST = ($urandom_range(0, 99) == 0);
            req[0] = ($urandom_range(0, 99) < 85);
            req[1] = ($urandom_range(0, 99) < 85);
            r0w = 3'($urandom); r0j = 3'($urandom);
            r1w = 3'($urandom); r1j = 3'($urandom);
            step(1);
        end
        RST = 1'b0;
        req = 2'b00;
        for (int i = 0; i < 4; i++) step(1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
